// File: rtl/hpdl_write_sequencer_if.sv
`timescale 1ns/1ps
// Signal bundle between the HPDL-1414 write sequencer, the display buffer and the displays.
// master: sequencer side; slave: buffer/display/requester side.
interface hpdl_write_sequencer_if;
  logic       UPDATE;
  logic       RD_EN;
  logic [3:0] RD_ADDR;
  logic [7:0] RD_DATA;
  logic [6:0] HPDL_D;
  logic [1:0] HPDL_A;
  logic [3:0] HPDL_WR_N;
  logic       BUSY;
  logic       FRAME_DONE;

  modport master (
    input  UPDATE, RD_DATA,
    output RD_EN, RD_ADDR, HPDL_D, HPDL_A, HPDL_WR_N, BUSY, FRAME_DONE
  );

  modport slave (
    output UPDATE, RD_DATA,
    input  RD_EN, RD_ADDR, HPDL_D, HPDL_A, HPDL_WR_N, BUSY, FRAME_DONE
  );
endinterface

// File: rtl/hpdl_write_sequencer.sv
`timescale 1ns/1ps
// Sweeps the 16-byte display buffer into four HPDL-1414 modules with timed setup/strobe/hold.
// Define HPDL_SKIP_UNCHANGED_EN to skip digits whose code matches the last one written.
module hpdl_write_sequencer #(
  parameter int unsigned T_SETUP_CYC = 2,
  parameter int unsigned T_WR_CYC    = 2,
  parameter int unsigned T_HOLD_CYC  = 1,
  parameter int unsigned REFRESH_CYC = 0
) (
  input logic                    CLK,
  input logic                    RST_N,
  hpdl_write_sequencer_if.master seq_if
);

  typedef enum logic [2:0] {StIdle, StRead, StLatch, StSetup, StStrobe, StHold} state_e;

  localparam logic [15:0] SetupLast   = 16'(T_SETUP_CYC - 1);
  localparam logic [15:0] WrLast      = 16'(T_WR_CYC - 1);
  localparam logic [15:0] HoldLast    = 16'(T_HOLD_CYC - 1);
  localparam bit          RefreshEn   = (REFRESH_CYC != 0);
  localparam logic [31:0] RefreshLast = 32'(REFRESH_CYC - 1);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] phase_q, phase_d;
  logic [31:0] refresh_q, refresh_d;
  logic        pending_q, pending_d;
  logic        rd_en_q, rd_en_d;
  logic [3:0]  rd_addr_q, rd_addr_d;
  logic [6:0]  hpdl_d_q, hpdl_d_d;
  logic [1:0]  hpdl_a_q, hpdl_a_d;
  logic [3:0]  wr_n_q, wr_n_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;

  logic [6:0]  code;
  logic        start;
  logic        skip;
  logic        advance;

  // Restrict to the HPDL-1414 glyph set; lowercase folds to uppercase, all else is blank.
  function automatic logic [6:0] map_char(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h5F) return c[6:0];
    if (c >= 8'h61 && c <= 8'h7A) return 7'(c - 8'h20);
    return 7'h20;
  endfunction

  assign code  = map_char(seq_if.RD_DATA);
  assign start = seq_if.UPDATE | pending_q | (RefreshEn && (refresh_q == RefreshLast));

`ifdef HPDL_SKIP_UNCHANGED_EN
  logic [6:0]  shadow_q [16];
  logic [15:0] shadow_vld_q;
  logic        shadow_we;

  // Shadow captures the code as the strobe begins, i.e. what the display actually latches.
  assign shadow_we = (state_q == StSetup) && (phase_q == SetupLast);
  assign skip      = shadow_vld_q[idx_q] && (shadow_q[idx_q] == code);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shadow_vld_q <= '0;
    end else if (shadow_we) begin
      shadow_vld_q[idx_q] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (shadow_we) shadow_q[idx_q] <= hpdl_d_q;
  end
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    phase_d      = phase_q;
    refresh_d    = refresh_q;
    pending_d    = pending_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    hpdl_d_d     = hpdl_d_q;
    hpdl_a_d     = hpdl_a_q;
    wr_n_d       = wr_n_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    advance      = 1'b0;

    // Any number of requests during a sweep collapse into a single follow-up sweep.
    if (state_q != StIdle && seq_if.UPDATE) pending_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pending_d = 1'b0;
          idx_d     = 4'd0;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = 4'd0;
          refresh_d = '0;
          state_d   = StRead;
        end else if (RefreshEn) begin
          refresh_d = refresh_q + 32'd1;
        end
      end
      StRead: state_d = StLatch;
      StLatch: begin
        hpdl_d_d = code;
        hpdl_a_d = ~idx_q[1:0];
        phase_d  = '0;
        if (skip) advance = 1'b1;
        else      state_d = StSetup;
      end
      StSetup: begin
        if (phase_q == SetupLast) begin
          phase_d = '0;
          wr_n_d  = ~(4'b0001 << idx_q[3:2]);
          state_d = StStrobe;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      StStrobe: begin
        if (phase_q == WrLast) begin
          phase_d = '0;
          wr_n_d  = 4'hF;
          state_d = StHold;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      StHold: begin
        if (phase_q == HoldLast) advance = 1'b1;
        else                     phase_d = phase_q + 16'd1;
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      if (idx_q == 4'd15) begin
        state_d      = StIdle;
        busy_d       = 1'b0;
        frame_done_d = 1'b1;
      end else begin
        idx_d     = idx_q + 4'd1;
        rd_en_d   = 1'b1;
        rd_addr_d = idx_q + 4'd1;
        state_d   = StRead;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= StIdle;
      idx_q        <= 4'd0;
      phase_q      <= '0;
      refresh_q    <= '0;
      pending_q    <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= 4'd0;
      hpdl_d_q     <= 7'h20;
      hpdl_a_q     <= 2'b00;
      wr_n_q       <= 4'hF;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      phase_q      <= phase_d;
      refresh_q    <= refresh_d;
      pending_q    <= pending_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      hpdl_d_q     <= hpdl_d_d;
      hpdl_a_q     <= hpdl_a_d;
      wr_n_q       <= wr_n_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seq_if.RD_EN      = rd_en_q;
  assign seq_if.RD_ADDR    = rd_addr_q;
  assign seq_if.HPDL_D     = hpdl_d_q;
  assign seq_if.HPDL_A     = hpdl_a_q;
  assign seq_if.HPDL_WR_N  = wr_n_q;
  assign seq_if.BUSY       = busy_q;
  assign seq_if.FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_hpdl_write_sequencer.sv
`timescale 1ns/1ps
// Bench for hpdl_write_sequencer: random buffers and request timing against a frame-level model.
// Build with HPDL_SKIP_UNCHANGED_EN to exercise unchanged-digit skipping.
module tb_hpdl_write_sequencer;
  localparam int ClkHalf = 42;
`ifdef HPDL_SKIP_UNCHANGED_EN
  localparam bit SkipEn = 1'b1;
`else
  localparam bit SkipEn = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] wr_n;
    logic [1:0] a;
    logic [6:0] d;
  } strobe_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #ClkHalf clk = ~clk;

  hpdl_write_sequencer_if u_if0 ();
  hpdl_write_sequencer_if u_if1 ();

  hpdl_write_sequencer u_dut0 (
    .CLK    (clk),
    .RST_N  (rst_n),
    .seq_if (u_if0)
  );

  hpdl_write_sequencer #(.REFRESH_CYC(200)) u_dut1 (
    .CLK    (clk),
    .RST_N  (rst_n),
    .seq_if (u_if1)
  );

  logic [7:0] mem [16];
  int checks = 0;
  int errors = 0;

  // Display buffer: one-cycle read latency, garbage when not enabled.
  always @(posedge clk) begin
    u_if0.RD_DATA <= u_if0.RD_EN ? mem[u_if0.RD_ADDR] : 8'($urandom);
    u_if1.RD_DATA <= u_if1.RD_EN ? 8'h41 : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_map(input int v);
    if (v >= 'h20 && v <= 'h5F) return 7'(v);
    if (v >= 'h61 && v <= 'h7A) return 7'(v - 'h20);
    return 7'h20;
  endfunction

  // Reference model: expected strobe list for one sweep of the buffer.
  strobe_t    exp_q[$];
  strobe_t    cap_q[$];
  logic [6:0] mshadow [16];
  bit         mvalid [16];

  task automatic model_frame();
    strobe_t e;
    logic [6:0] c;
    for (int i = 0; i < 16; i++) begin
      c = ref_map(int'(mem[i]));
      if (!(SkipEn && mvalid[i] && mshadow[i] == c)) begin
        e.wr_n = 4'hF ^ 4'(1 << (i / 4));
        e.a    = 2'(3 - (i % 4));
        e.d    = c;
        exp_q.push_back(e);
        mshadow[i] = c;
        mvalid[i]  = 1'b1;
      end
    end
  endtask

  logic [3:0] prev_wr;
  logic [8:0] prev_da;
  bit         prev_busy, strobed;
  int         stable, low_cnt, hold_cnt;
  int         strobe_cnt = 0;
  int         frame_cnt = 0;

  always @(negedge clk) begin
    strobe_t e, s;
    if (!rst_n) begin
      exp_q.delete();
      low_cnt = 0; stable = 0; hold_cnt = 0; strobed = 0; prev_busy = 0;
      for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
      prev_wr = u_if0.HPDL_WR_N;
      prev_da = {u_if0.HPDL_D, u_if0.HPDL_A};
    end else begin
      if (u_if0.BUSY && !prev_busy) model_frame();
      if ({u_if0.HPDL_D, u_if0.HPDL_A} != prev_da) begin
        if (strobed) check("hold_after_wr", 32'(hold_cnt >= 1), 1);
        strobed = 0;
        stable  = 0;
      end else begin
        stable++;
      end
      if (u_if0.HPDL_WR_N != 4'hF && prev_wr == 4'hF) begin
        strobe_cnt++;
        s = '{u_if0.HPDL_WR_N, u_if0.HPDL_A, u_if0.HPDL_D};
        cap_q.push_back(s);
        check("one_wr_low", $countones(~u_if0.HPDL_WR_N), 1);
        check("setup_cycles", stable, 2);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_n", u_if0.HPDL_WR_N, e.wr_n);
          check("hpdl_a", u_if0.HPDL_A, e.a);
          check("hpdl_d", u_if0.HPDL_D, e.d);
        end
      end
      if (u_if0.HPDL_WR_N != 4'hF) begin
        low_cnt++;
      end else if (prev_wr != 4'hF) begin
        check("wr_low_cycles", low_cnt, 2);
        check("da_stable_thru_wr", stable, 4);
        low_cnt  = 0;
        hold_cnt = 0;
        strobed  = 1;
      end else begin
        hold_cnt++;
      end
      if (u_if0.FRAME_DONE) begin
        frame_cnt++;
        check("frame_all_strobed", exp_q.size(), 0);
      end
      prev_wr   = u_if0.HPDL_WR_N;
      prev_da   = {u_if0.HPDL_D, u_if0.HPDL_A};
      prev_busy = u_if0.BUSY;
    end
  end

  task automatic pulse_update();
    u_if0.UPDATE = 1'b1;
    @(posedge clk); #1;
    u_if0.UPDATE = 1'b0;
  endtask

  task automatic wait_quiet();
    int idle = 0;
    int n = 0;
    while (idle < 4 && n < 4000) begin
      @(posedge clk); #1;
      n++;
      if (u_if0.BUSY) idle = 0;
      else            idle++;
    end
    if (idle < 4) check("quiet_timeout", 0, 1);
  endtask

  task automatic wait_fd1();
    int n = 0;
    bit ok = 0;
    while (!ok && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (u_if1.FRAME_DONE) ok = 1;
    end
    if (!ok) check("refresh_frame_timeout", 0, 1);
  endtask

  // Called on the FRAME_DONE sample, which is the first idle cycle.
  task automatic idle_gap1(output int gap);
    gap = 1;
    while (gap < 1000) begin
      @(posedge clk); #1;
      if (u_if1.BUSY) break;
      gap++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #(ClkHalf * 2 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, f0, s0, d1, d2, d3, extras, gap;
    bit issued;
    u_if0.UPDATE = 1'b0;
    u_if1.UPDATE = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h20;
    repeat (2) @(posedge clk); #1;
    check("rst_wr_n", u_if0.HPDL_WR_N, 4'hF);
    check("rst_d", u_if0.HPDL_D, 7'h20);
    check("rst_a", u_if0.HPDL_A, 2'b00);
    check("rst_busy", u_if0.BUSY, 0);
    check("rst_frame_done", u_if0.FRAME_DONE, 0);
    check("rst_rd_en", u_if0.RD_EN, 0);
    check("rst_rd_addr", u_if0.RD_ADDR, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("idle_busy", u_if0.BUSY, 0);
    check("idle_wr_n", u_if0.HPDL_WR_N, 4'hF);

    fork
      begin
        // "0123456789ABCDEF": latency and explicit digit-5 values.
        for (int i = 0; i < 16; i++) mem[i] = (i < 10) ? 8'(48 + i) : 8'(55 + i);
        cap_q.delete();
        u_if0.UPDATE = 1'b1;
        k = 0;
        while (k < 400) begin
          @(posedge clk); #1;
          k++;
          if (k == 1) begin
            u_if0.UPDATE = 1'b0;
            check("busy_rise", u_if0.BUSY, 1);
          end
          if (u_if0.FRAME_DONE) break;
        end
        check("frame_done_latency", k, 113);
        check("busy_drop_with_done", u_if0.BUSY, 0);
        wait_quiet();
        check("frame1_strobes", cap_q.size(), 16);
        if (cap_q.size() == 16) begin
          check("idx5_wr_n", cap_q[5].wr_n, 4'b1101);
          check("idx5_a", cap_q[5].a, 2'b10);
          check("idx5_d", cap_q[5].d, 7'h35);
        end

        // Character map corner bytes.
        mem[0] = 8'h61; mem[1] = 8'h7B; mem[2] = 8'h1F; mem[3] = 8'h5F;
        cap_q.delete();
        pulse_update();
        wait_quiet();
        check("map_strobes", cap_q.size(), SkipEn ? 4 : 16);
        if (cap_q.size() >= 4) begin
          check("map_61", cap_q[0].d, 7'h41);
          check("map_7b", cap_q[1].d, 7'h20);
          check("map_1f", cap_q[2].d, 7'h20);
          check("map_5f", cap_q[3].d, 7'h5F);
        end

        // Three requests inside one sweep collapse into one more sweep.
        for (int i = 0; i < 16; i++) mem[i] = 8'(71 + i);
        f0 = frame_cnt; s0 = strobe_cnt;
        pulse_update();
        repeat (10) @(posedge clk); #1;
        pulse_update();
        repeat (20) @(posedge clk); #1;
        pulse_update();
        repeat (20) @(posedge clk); #1;
        pulse_update();
        wait_quiet();
        check("triple_frames", frame_cnt - f0, 2);
        check("triple_strobes", strobe_cnt - s0, SkipEn ? 16 : 32);

        // Random buffers and random extra requests during the first sweep.
        for (int r = 0; r < 6; r++) begin
          for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
          f0 = frame_cnt;
          pulse_update();
          extras = $urandom_range(0, 3);
          issued = 0;
          for (int e = 0; e < extras; e++) begin
            repeat ($urandom_range(1, 30)) @(posedge clk);
            #1;
            if (u_if0.BUSY && frame_cnt == f0) begin
              pulse_update();
              issued = 1;
            end
          end
          wait_quiet();
          check("rand_frames", frame_cnt - f0, issued ? 2 : 1);
        end
      end
      begin
        // Auto refresh every 200 idle cycles; UPDATE on the expiry cycle starts one sweep.
        wait_fd1();
        idle_gap1(gap);
        check("refresh_gap_a", gap, 200);
        wait_fd1();
        idle_gap1(gap);
        check("refresh_gap_b", gap, 200);
        wait_fd1();
        repeat (198) @(posedge clk);
        #1;
        @(posedge clk); #1;
        check("pre_expiry_idle", u_if1.BUSY, 0);
        u_if1.UPDATE = 1'b1;
        @(posedge clk); #1;
        u_if1.UPDATE = 1'b0;
        check("coincide_busy", u_if1.BUSY, 1);
        wait_fd1();
        idle_gap1(gap);
        check("coincide_single_sweep", gap, 200);
      end
    join

    // Unchanged buffer: full sweep, then nothing (skip) or full again, then one changed digit.
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
    s0 = strobe_cnt; pulse_update(); wait_quiet(); d1 = strobe_cnt - s0;
    s0 = strobe_cnt; pulse_update(); wait_quiet(); d2 = strobe_cnt - s0;
    mem[9] = (ref_map(int'(mem[9])) == 7'h41) ? 8'h42 : 8'h41;
    cap_q.delete();
    s0 = strobe_cnt; pulse_update(); wait_quiet(); d3 = strobe_cnt - s0;
    check("skip_sweep1", d1, 16);
    check("skip_sweep2", d2, SkipEn ? 0 : 16);
    check("skip_sweep3", d3, SkipEn ? 1 : 16);
    if (SkipEn && cap_q.size() == 1) check("skip_changed_wr_n", cap_q[0].wr_n, 4'b1011);

    // Reset during a strobe releases WR_N without waiting for a clock edge.
    pulse_update();
    k = 0;
    while (u_if0.HPDL_WR_N == 4'hF && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("strobe_seen", 32'(u_if0.HPDL_WR_N != 4'hF), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_wr_release", u_if0.HPDL_WR_N, 4'hF);
    check("async_busy", u_if0.BUSY, 0);
    check("async_d", u_if0.HPDL_D, 7'h20);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("post_reset_idle", u_if0.BUSY, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
